// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient magnitude: 16-pixel beats in, one 8-bit result per interior pixel out.
// Optional build macro SOBEL_THRESHOLD_EN binarises the output against THRESHOLD.
module sobel_gradient #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int THRESHOLD  = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic [7:0]   data_out,
    output logic         valid_out
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    generate
        if ((IMG_WIDTH % 16) != 0 || IMG_WIDTH < 16 || IMG_HEIGHT < 3 ||
            THRESHOLD < 0 || THRESHOLD > 255) begin : g_bad_param
            $error("sobel_gradient: illegal parameter value");
        end
    endgenerate

    logic [127:0]  r_beat;
    logic [3:0]    r_idx;
    logic          r_busy;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_lb1 [0:IMG_WIDTH-1];
    logic [7:0]    r_lb2 [0:IMG_WIDTH-1];
    logic [7:0]    r_p00, r_p01, r_p02, r_p10, r_p11, r_p12, r_p20, r_p21, r_p22;
    logic          r_v0;

    logic               w_accept;
    logic               w_pix_en;
    logic [7:0]         w_pix;
    logic [7:0]         w_top;
    logic [7:0]         w_mid;
    logic               w_interior;
    logic [10:0]        w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic signed [10:0] w_gx, w_gy;
    logic [10:0]        w_ax, w_ay;
    logic [11:0]        w_mag;
    logic [7:0]         w_result;

    // An empty serialiser passes byte 0 straight through, so a beat taken on pixel 15 keeps the stream gap-free.
    assign ready_out  = ~rst & (~r_busy | (r_idx == 4'd15));
    assign w_accept   = valid_in & ready_out;
    assign w_pix_en   = ~rst & (r_busy | w_accept);
    assign w_pix      = r_busy ? r_beat[{r_idx, 3'b000} +: 8] : data_in[7:0];
    assign w_top      = r_lb2[r_col];
    assign w_mid      = r_lb1[r_col];
    assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));

    assign w_gx_pos = {3'b000, r_p02} + {2'b00, r_p12, 1'b0} + {3'b000, r_p22};
    assign w_gx_neg = {3'b000, r_p00} + {2'b00, r_p10, 1'b0} + {3'b000, r_p20};
    assign w_gy_pos = {3'b000, r_p20} + {2'b00, r_p21, 1'b0} + {3'b000, r_p22};
    assign w_gy_neg = {3'b000, r_p00} + {2'b00, r_p01, 1'b0} + {3'b000, r_p02};
    assign w_gx     = $signed(w_gx_pos) - $signed(w_gx_neg);
    assign w_gy     = $signed(w_gy_pos) - $signed(w_gy_neg);
    assign w_ax     = w_gx[10] ? 11'(-w_gx) : 11'(w_gx);
    assign w_ay     = w_gy[10] ? 11'(-w_gy) : 11'(w_gy);
    assign w_mag    = {1'b0, w_ax} + {1'b0, w_ay};

    // Final pixel value: binarised or saturated magnitude.
    always_comb begin
        w_result = 8'h00;
`ifdef SOBEL_THRESHOLD_EN
        if (w_mag >= 12'(THRESHOLD)) begin
            w_result = 8'hFF;
        end else begin
            w_result = 8'h00;
        end
`else
        if (w_mag > 12'd255) begin
            w_result = 8'hFF;
        end else begin
            w_result = w_mag[7:0];
        end
`endif
    end

    // Beat holding register and pixel index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= 128'd0;
            r_idx  <= 4'd0;
            r_busy <= 1'b0;
        end else if (w_accept) begin
            r_beat <= data_in;
            r_idx  <= r_busy ? 4'd0 : 4'd1;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_idx  <= r_idx + 4'd1;
            r_busy <= (r_idx != 4'd15);
        end
    end

    // Raster position of the pixel being serialised.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pix_en) begin
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers and 3x3 window; contents survive reset because new rows overwrite them before use.
    always_ff @(posedge clk) begin
        if (w_pix_en) begin
            r_lb2[r_col] <= w_mid;
            r_lb1[r_col] <= w_pix;
            r_p00 <= r_p01;
            r_p01 <= r_p02;
            r_p02 <= w_top;
            r_p10 <= r_p11;
            r_p11 <= r_p12;
            r_p12 <= w_mid;
            r_p20 <= r_p21;
            r_p21 <= r_p22;
            r_p22 <= w_pix;
        end
    end

    // Two-stage result pipeline; data_out only moves when a result is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0      <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= 8'h00;
        end else begin
            r_v0      <= w_pix_en & w_interior;
            valid_out <= r_v0;
            if (r_v0) begin
                data_out <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient.sv
// Self-checking bench for sobel_gradient on a 16x4 image: directed table plus random frames against a 2-D reference.
module tb_sobel_gradient;

    localparam int W   = 16;
    localparam int H   = 4;
    localparam int THR = 128;
    localparam int NOUT = (W - 2) * (H - 2);

    logic         clk;
    logic         rst;
    logic [127:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic [7:0]   data_out;
    logic         valid_out;

    sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(THR)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int val; } exp_t;
    typedef struct { int kind; int gap; int exp_edge; int exp_other; } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   img [0:H-1][0:W-1];
    exp_t exp_q [$];
    int   acc_q [$];
    int   obs [0:NOUT-1];
    int   n_out = 0;
    int   cyc = 0;
    int   last_s = -1000;
    int   pos = 0;
    int   last_dout = 0;
    bit   started = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Sobel result for the window whose newest pixel is (r,c), computed directly on the image.
    function automatic int ref_pix(input int r, input int c);
        int gx, gy, mag;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        mag = iabs(gx) + iabs(gy);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= THR) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    // Monitor: derives pixel timing from observed accepts and checks every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                last_s    = -1000;
                pos       = 0;
                last_dout = 0;
                n_out     = 0;
                started   = 1;
            end else if (started) begin
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_value", int'(data_out), e.val);
                        chk("out_cycle", cyc, e.cyc);
                    end
                    if (n_out < NOUT) obs[n_out] = int'(data_out);
                    n_out++;
                    last_dout = int'(data_out);
                end else begin
                    chk("hold_data", int'(data_out), last_dout);
                end
                if (valid_in && ready_out) begin
                    int s;
                    acc_q.push_back(cyc);
                    s = (cyc > last_s + 15) ? cyc : last_s + 16;
                    last_s = s;
                    for (int k = 0; k < 16; k++) begin
                        int r, c;
                        exp_t e;
                        r = pos / W;
                        c = pos % W;
                        if (r >= 2 && c >= 2) begin
                            e.cyc = s + k + 2;
                            e.val = ref_pix(r, c);
                            exp_q.push_back(e);
                        end
                        pos = (pos + 1) % (W * H);
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [127:0] d);
        bit got;
        got      = 0;
        valid_in = 1'b1;
        data_in  = d;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = ready_out;
        end
        chk("ready_seen", int'(got), 1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_row(input int b);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(img[b][k]);
        send_beat(d);
    endtask

    task automatic run_frame(input int gap);
        for (int b = 0; b < H; b++) begin
            int g;
            send_row(b);
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic fill_img(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (kind == 0)      img[r][c] = 8'h40;
                else if (kind == 1) img[r][c] = (c < 8) ? 0 : 255;
                else if (kind == 2) img[r][c] = (c < 8) ? 0 : 25;
                else                img[r][c] = int'($urandom_range(0, 255));
            end
    endtask

    task automatic drain_and_count();
        repeat (20) @(posedge clk);
        #1;
        chk("frame_count", n_out, NOUT);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vt [0:8];
        int   e25;
`ifdef SOBEL_THRESHOLD_EN
        e25 = 0;
`else
        e25 = 100;
`endif
        vt[0] = '{0,  0, 0,   0};
        vt[1] = '{1,  0, 255, 0};
        vt[2] = '{2,  0, e25, 0};
        vt[3] = '{1,  2, 255, 0};
        vt[4] = '{3, -1, -1, -1};
        vt[5] = '{3, -1, -1, -1};
        vt[6] = '{3,  0, -1, -1};
        vt[7] = '{3,  1, -1, -1};
        vt[8] = '{3, -1, -1, -1};

        clk      = 1'b0;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 128'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", int'(ready_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("idle_ready_high", int'(ready_out), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i <= 8; i++) begin
            fill_img(vt[i].kind);
            n_out = 0;
            acc_q.delete();
            run_frame(vt[i].gap);
            drain_and_count();
            if (vt[i].exp_edge >= 0) begin
                for (int j = 0; j < NOUT; j++) begin
                    int ctr;
                    ctr = 2 + (j % (W - 2)) - 1;
                    chk("table_value", obs[j],
                        (ctr == 7 || ctr == 8) ? vt[i].exp_edge : vt[i].exp_other);
                end
            end
            if (vt[i].kind == 0 && vt[i].gap == 0) begin
                chk("accepts_in_frame", acc_q.size(), 4);
                if (acc_q.size() == 4) begin
                    chk("ready_cycle_15", acc_q[1] - acc_q[0], 15);
                    chk("ready_cycle_31", acc_q[2] - acc_q[0], 31);
                    chk("ready_cycle_47", acc_q[3] - acc_q[0], 47);
                    chk("last_pixel_cycle", acc_q[3] + 1 + 15 - acc_q[0], 63);
                end
            end
        end

        // Reset while row 2 col 5 is being serialised, then a clean frame.
        fill_img(3);
        send_row(0);
        send_row(1);
        send_row(2);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready_low", int'(ready_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid_low", int'(valid_out), 0);
        chk("midrst_data_zero", int'(data_out), 0);
        @(posedge clk);
        #1;
        fill_img(3);
        n_out = 0;
        run_frame(0);
        drain_and_count();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sobel_gradient.md
SOBEL_GRADIENT -- requirements
Module: sobel_gradient

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: pixels per line; legal values are multiples of 16, minimum 16.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480: lines per frame; minimum 3.
REQ-003 SHALL have parameter THRESHOLD, default 128: 8-bit binarisation level, used only under REQ-024.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_in, input, 128 bits: 16 luma pixels per beat; bits [7:0] are the first pixel in raster order, bits [127:120] the last.
REQ-007 SHALL have port valid_in, input, 1 bit: data_in holds a beat.
REQ-008 SHALL have port ready_out, output, 1 bit: the block accepts a beat this cycle.
REQ-009 SHALL have port data_out, output, 8 bits: gradient result for one interior pixel.
REQ-010 SHALL have port valid_out, output, 1 bit: data_out is valid this cycle; no downstream backpressure.

Function
REQ-011 SHALL accept a beat on any cycle where valid_in and ready_out are both high.
REQ-012 SHALL serialise each accepted beat into one pixel per cycle, byte 0 first, over 16 consecutive cycles.
REQ-013 SHALL drive ready_out high when the serialiser is empty or is on pixel 15 of a beat, so that back-to-back beats sustain 1 pixel per cycle with no bubble.
REQ-014 SHALL keep column (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters; the column wraps to 0 with a row increment, and after the last pixel both wrap to 0 (next pixel is (0,0) of a new frame).
REQ-015 SHALL hold two line buffers of IMG_WIDTH x 8 bits (rows r-1, r-2) and a 3x3 window register that shifts on every serialised pixel.
REQ-016 SHALL compute Gx = (p02+2*p12+p22)-(p00+2*p10+p20) and Gy = (p20+2*p21+p22)-(p00+2*p01+p02) as 11-bit signed values (pRC: R = row, C = column in window, 00 = oldest).
REQ-017 SHALL compute mag = |Gx|+|Gy| in 12 bits unsigned and saturate it to 255 for data_out.
REQ-018 SHALL emit exactly one output per input pixel at row>=2 and col>=2, for the window centred on (row-1,col-1); this gives (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame, and border pixels are not emitted.
REQ-019 SHALL assert valid_out exactly 2 cycles after the cycle in which the triggering pixel is serialised.
REQ-020 SHALL hold data_out at its last value while valid_out is low.
REQ-021 SHALL let input gaps (valid_in low) stall the serialiser and counters without corrupting window or line-buffer state.

Reset
REQ-022 SHALL on rst: clear serialiser, column/row counters and pipeline valids; set valid_out=0, data_out=0, ready_out=0 for the reset cycle; leave line-buffer contents unreset.
REQ-023 SHALL on rst mid-frame discard the partial frame and in-flight results; the first beat accepted after rst deasserts is pixel (0,0).

Configuration
REQ-024 SHALL, with macro SOBEL_THRESHOLD_EN defined, output data_out = 255 when mag >= THRESHOLD and 0 otherwise; without the macro, output the saturated magnitude per REQ-017, with THRESHOLD unused.

Verification (IMG_WIDTH=16, IMG_HEIGHT=4)
REQ-025 SHALL cover: flat frame, all pixels 0x40, streamed back-to-back -> 28 outputs, all 0x00; 4 beats accepted in 64 cycles; ready_out high on cycles 0,15,31,47.
REQ-026 SHALL cover: vertical step, cols 0-7 = 0x00 and cols 8-15 = 0xFF -> outputs at centre cols 7 and 8 = 0xFF (Gx=1020, saturated); all others 0x00.
REQ-027 SHALL cover: step of 25 (cols 0-7 = 0, cols 8-15 = 25) -> centre cols 7/8 = 100 without SOBEL_THRESHOLD_EN; = 0 with it (THRESHOLD=128).
REQ-028 SHALL cover: valid_in toggling 1-0-0-1 between beats -> output values and count identical to REQ-026; each valid_out exactly 2 cycles after its pixel is serialised.
REQ-029 SHALL cover: rst pulsed at row 2 col 5, then a full clean frame -> no valid_out until row 2 col 2 of the new frame; exactly 28 outputs, matching the clean-frame reference.
